// File: rtl/ttt_token_router.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_token_router
//  Purpose  : Initiator and receiver at the far end of the token network
//             connection-iteration protocol. It walks the outgoing connections
//             of every processor that fired this round, lowest index first.
//             For each one it issues load-range, then iterate until the
//             network reports done, then NOP. Every valid (target, good, bad)
//             triple is added into saturating per-processor counters.
//
//  Ports    : clk, reset           clock, synchronous active-high reset
//             start, fire_mask     begin a round over the fired processors
//             clear_tokens         zero all counters (only while idle)
//             busy, round_done     status; round_done is a one-cycle pulse
//             net_processor_id     processor currently being iterated
//             net_instruction      000 NOP, 110 load range, 111 iterate
//             net_valid/net_done   network triple valid / processor finished
//             net_target_id        destination processor of the triple
//             net_new_good_tokens  signed good-token delta
//             net_new_bad_tokens   signed bad-token delta
//             tok_rd_id            counter read address
//             tok_good/tok_bad     combinational counter read data
//
//  Revision : 1.0  initial release
// ============================================================================
module ttt_token_router #(
   parameter int NUM_PROCESSORS  = 4,
   parameter int NEW_TOKENS_BITS = 4,
   parameter int TOKEN_BITS      = 8,
   // Widened above $clog2 when the network can emit out-of-range target ids.
   parameter int PID_W           = $clog2(NUM_PROCESSORS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [NUM_PROCESSORS-1:0]         fire_mask,
   input  logic                              clear_tokens,
   output logic                              busy,
   output logic                              round_done,
   output logic [PID_W-1:0]                  net_processor_id,
   output logic [2:0]                        net_instruction,
   input  logic                              net_valid,
   input  logic                              net_done,
   input  logic [PID_W-1:0]                  net_target_id,
   input  logic signed [NEW_TOKENS_BITS-1:0] net_new_good_tokens,
   input  logic signed [NEW_TOKENS_BITS-1:0] net_new_bad_tokens,
   input  logic [PID_W-1:0]                  tok_rd_id,
   output logic signed [TOKEN_BITS-1:0]      tok_good,
   output logic signed [TOKEN_BITS-1:0]      tok_bad
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_scan   = 3'd1;
   localparam logic [2:0] c_st_load   = 3'd2;
   localparam logic [2:0] c_st_iter   = 3'd3;
   localparam logic [2:0] c_st_flush  = 3'd4;
   localparam logic [2:0] c_st_finish = 3'd5;

   localparam logic [2:0] c_ins_nop  = 3'b000;
   localparam logic [2:0] c_ins_load = 3'b110;
   localparam logic [2:0] c_ins_iter = 3'b111;

   localparam logic [NUM_PROCESSORS-1:0] c_mask_one = NUM_PROCESSORS'(1);

   // -------------------------------------------------------------------------
   // Signals
   // -------------------------------------------------------------------------
   logic [2:0]                     r_state;
   logic [2:0]                     w_state_nxt;
   logic [NUM_PROCESSORS-1:0]      r_pending;
   logic                           w_pend_any;
   logic [PID_W-1:0]               w_low_idx;

   logic                           w_busy_nxt;
   logic                           w_round_done_nxt;
   logic [2:0]                     w_ins_nxt;
   logic [PID_W-1:0]               w_pid_nxt;

   logic                           w_clear;
   logic                           w_acc;

   logic signed [TOKEN_BITS-1:0]   r_good [NUM_PROCESSORS];
   logic signed [TOKEN_BITS-1:0]   r_bad  [NUM_PROCESSORS];

   // -------------------------------------------------------------------------
   // Signed saturating add of a narrow delta into a counter. One guard bit is
   // enough because the delta is never wider than the counter; overflow shows
   // up as the guard bit disagreeing with the counter sign bit.
   // -------------------------------------------------------------------------
   function automatic logic signed [TOKEN_BITS-1:0] sat_add(
      input logic signed [TOKEN_BITS-1:0]      a,
      input logic signed [NEW_TOKENS_BITS-1:0] d
   );
      logic [TOKEN_BITS:0] sum;
      sum = {a[TOKEN_BITS-1], a}
          + {{(TOKEN_BITS + 1 - NEW_TOKENS_BITS){d[NEW_TOKENS_BITS-1]}}, d};
      if (sum[TOKEN_BITS] != sum[TOKEN_BITS-1]) begin
         if (sum[TOKEN_BITS])
            sat_add = {1'b1, {(TOKEN_BITS-1){1'b0}}};
         else
            sat_add = {1'b0, {(TOKEN_BITS-1){1'b1}}};
      end else begin
         sat_add = sum[TOKEN_BITS-1:0];
      end
   endfunction

   // -------------------------------------------------------------------------
   // Pending-mask helpers: lowest set bit wins so processors go in index order.
   // -------------------------------------------------------------------------
   assign w_pend_any = |r_pending;

   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_PROCESSORS - 1; i >= 0; i--) begin
         if (r_pending[i])
            w_low_idx = PID_W'(i);
      end
   end

   // -------------------------------------------------------------------------
   // FSM: state and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= c_st_idle;
         busy             <= 1'b0;
         round_done       <= 1'b0;
         net_instruction  <= c_ins_nop;
         net_processor_id <= '0;
      end else begin
         r_state          <= w_state_nxt;
         busy             <= w_busy_nxt;
         round_done       <= w_round_done_nxt;
         net_instruction  <= w_ins_nxt;
         net_processor_id <= w_pid_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:   if (start) w_state_nxt = c_st_scan;
         c_st_scan:   w_state_nxt = w_pend_any ? c_st_load : c_st_finish;
         c_st_load:   w_state_nxt = c_st_iter;
         c_st_iter:   if (net_done) w_state_nxt = c_st_flush;
         c_st_flush:  w_state_nxt = c_st_scan;
         c_st_finish: w_state_nxt = c_st_idle;
         default:     w_state_nxt = c_st_idle;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: output logic. Outputs are decoded from the next state and then
   // registered, so they line up with the state they describe.
   // -------------------------------------------------------------------------
   always_comb begin
      w_busy_nxt       = (w_state_nxt != c_st_idle);
      w_round_done_nxt = (w_state_nxt == c_st_finish);
      case (w_state_nxt)
         c_st_load: w_ins_nxt = c_ins_load;
         c_st_iter: w_ins_nxt = c_ins_iter;
         default:   w_ins_nxt = c_ins_nop;
      endcase
      // The id only moves when SCAN picks the next processor, which keeps it
      // stable across LOAD, ITER and FLUSH.
      w_pid_nxt = net_processor_id;
      if (r_state == c_st_scan && w_pend_any)
         w_pid_nxt = w_low_idx;
   end

   // -------------------------------------------------------------------------
   // Pending mask
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else if (r_state == c_st_idle && start) begin
         r_pending <= fire_mask;
      end else if (r_state == c_st_scan && w_pend_any) begin
         // x & (x - 1) drops exactly the lowest set bit.
         r_pending <= r_pending & (r_pending - c_mask_one);
      end
   end

   // -------------------------------------------------------------------------
   // Token counters. A target id outside the processor range matches no
   // counter, so such triples are dropped without any explicit check.
   // -------------------------------------------------------------------------
   assign w_clear = (r_state == c_st_idle) && clear_tokens;
   assign w_acc   = (r_state == c_st_iter) && net_valid;

   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            r_good[i] <= '0;
            r_bad[i]  <= '0;
         end
      end else if (w_acc) begin
         for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if (net_target_id == PID_W'(i)) begin
               r_good[i] <= sat_add(r_good[i], net_new_good_tokens);
               r_bad[i]  <= sat_add(r_bad[i],  net_new_bad_tokens);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Combinational read port; out-of-range addresses read as zero.
   // -------------------------------------------------------------------------
   always_comb begin
      tok_good = '0;
      tok_bad  = '0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
         if (tok_rd_id == PID_W'(i)) begin
            tok_good = r_good[i];
            tok_bad  = r_bad[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ttt_token_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttt_token_router
//  Purpose  : Directed bench for ttt_token_router. A small behavioural network
//             answers load/iterate with a programmed connection list and an
//             independent saturating model tracks the expected counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ttt_token_router;

   localparam int NP  = 4;
   localparam int NTB = 4;
   localparam int TB  = 8;
   localparam int PW  = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [NP-1:0]         fire_mask;
   logic                  clear_tokens;
   logic                  busy;
   logic                  round_done;
   logic [PW-1:0]         net_processor_id;
   logic [2:0]            net_instruction;
   logic                  net_valid;
   logic                  net_done;
   logic [PW-1:0]         net_target_id;
   logic signed [NTB-1:0] net_new_good_tokens;
   logic signed [NTB-1:0] net_new_bad_tokens;
   logic [PW-1:0]         tok_rd_id;
   logic signed [TB-1:0]  tok_good;
   logic signed [TB-1:0]  tok_bad;

   ttt_token_router #(
      .NUM_PROCESSORS  (NP),
      .NEW_TOKENS_BITS (NTB),
      .TOKEN_BITS      (TB),
      .PID_W           (PW)
   ) u_dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .fire_mask           (fire_mask),
      .clear_tokens        (clear_tokens),
      .busy                (busy),
      .round_done          (round_done),
      .net_processor_id    (net_processor_id),
      .net_instruction     (net_instruction),
      .net_valid           (net_valid),
      .net_done            (net_done),
      .net_target_id       (net_target_id),
      .net_new_good_tokens (net_new_good_tokens),
      .net_new_bad_tokens  (net_new_bad_tokens),
      .tok_rd_id           (tok_rd_id),
      .tok_good            (tok_good),
      .tok_bad             (tok_bad)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // programmed network: per source processor, a list of connections
   int prog_n [NP];
   int prog_t [NP][8];
   int prog_g [NP][8];
   int prog_b [NP][8];

   // expected counters
   int exp_g [NP];
   int exp_b [NP];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 127)       return 127;
      else if (v < -128) return -128;
      else               return v;
   endfunction

   task automatic set_conn(input int src, input int k, input int t, input int g, input int b);
      prog_t[src][k] = t;
      prog_g[src][k] = g;
      prog_b[src][k] = b;
   endtask

   task automatic zero_exp();
      for (int i = 0; i < NP; i++) begin
         exp_g[i] = 0;
         exp_b[i] = 0;
      end
   endtask

   task automatic check_counters(input string tag);
      for (int i = 0; i < NP; i++) begin
         tok_rd_id = PW'(i);
         #1;
         chk({tag, "_good"}, int'(tok_good), exp_g[i]);
         chk({tag, "_bad"},  int'(tok_bad),  exp_b[i]);
      end
   endtask

   // Wait (bounded) at negedges for the load-range instruction.
   task automatic wait_load(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (net_instruction == 3'b110) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("load_timeout", 0, 1);
   endtask

   // Entered at the negedge where LOAD is visible; leaves at the FLUSH negedge.
   task automatic serve_proc(input int pid, input bit disturb);
      chk("ins_load", net_instruction, 3'b110);
      chk("pid_load", net_processor_id, pid);
      net_valid = 1'b0;
      net_done  = 1'b0;
      @(negedge clk);
      chk("ins_iter", net_instruction, 3'b111);
      if (disturb) begin
         start        = 1'b1;
         clear_tokens = 1'b1;
         fire_mask    = 4'hF;
      end
      for (int k = 0; k < prog_n[pid]; k++) begin
         @(negedge clk);
         start        = 1'b0;
         clear_tokens = 1'b0;
         chk("ins_iter", net_instruction, 3'b111);
         chk("pid_iter", net_processor_id, pid);
         net_valid           = 1'b1;
         net_target_id       = PW'(prog_t[pid][k]);
         net_new_good_tokens = NTB'(prog_g[pid][k]);
         net_new_bad_tokens  = NTB'(prog_b[pid][k]);
         if (prog_t[pid][k] < NP) begin
            exp_g[prog_t[pid][k]] = sat(exp_g[prog_t[pid][k]] + prog_g[pid][k]);
            exp_b[prog_t[pid][k]] = sat(exp_b[prog_t[pid][k]] + prog_b[pid][k]);
         end
      end
      @(negedge clk);
      start        = 1'b0;
      clear_tokens = 1'b0;
      chk("ins_iter", net_instruction, 3'b111);
      net_valid = 1'b0;
      net_done  = 1'b1;
      @(negedge clk);
      net_done = 1'b0;
      chk("ins_flush", net_instruction, 3'b000);
      chk("pid_flush", net_processor_id, pid);
      chk("busy_flush", busy, 1);
   endtask

   task automatic run_round(input logic [NP-1:0] mask, input bit disturb, input bit with_clear);
      bit ok;
      bit first;
      @(negedge clk);
      start        = 1'b1;
      clear_tokens = with_clear;
      fire_mask    = mask;
      if (with_clear) zero_exp();
      @(negedge clk);
      start        = 1'b0;
      clear_tokens = 1'b0;
      chk("busy_scan", busy, 1);
      first = 1'b1;
      for (int p = 0; p < NP; p++) begin
         if (mask[p]) begin
            wait_load(ok);
            if (ok) serve_proc(p, disturb && first);
            first = 1'b0;
         end
      end
      ok = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (round_done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("round_done", round_done, 1);
      @(negedge clk);
      chk("round_done_pulse", round_done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset               = 1'b1;
      start               = 1'b0;
      fire_mask           = '0;
      clear_tokens        = 1'b0;
      net_valid           = 1'b0;
      net_done            = 1'b0;
      net_target_id       = '0;
      net_new_good_tokens = '0;
      net_new_bad_tokens  = '0;
      tok_rd_id           = '0;
      zero_exp();
      for (int i = 0; i < NP; i++) prog_n[i] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_round_done", round_done, 0);
      chk("rst_ins", net_instruction, 0);
      chk("rst_pid", net_processor_id, 0);
      check_counters("rst");

      // empty mask: IDLE, SCAN, FINISH
      start     = 1'b1;
      fire_mask = 4'b0000;
      @(negedge clk);
      start = 1'b0;
      chk("empty_busy1", busy, 1);
      chk("empty_rd1", round_done, 0);
      @(negedge clk);
      chk("empty_busy2", busy, 1);
      chk("empty_rd2", round_done, 1);
      chk("empty_ins", net_instruction, 0);
      @(negedge clk);
      chk("empty_busy3", busy, 0);
      chk("empty_rd3", round_done, 0);
      check_counters("empty");

      // P0 -> {P1:+3/-1, P2:+2/0}
      prog_n[0] = 2;
      set_conn(0, 0, 1, 3, -1);
      set_conn(0, 1, 2, 2, 0);
      run_round(4'b0001, 1'b0, 1'b0);
      check_counters("p0");

      // clear together with start; P1 -> P3:+1/+1, P3 -> P0:-2/+4
      prog_n[1] = 1;
      set_conn(1, 0, 3, 1, 1);
      prog_n[3] = 1;
      set_conn(3, 0, 0, -2, 4);
      run_round(4'b1010, 1'b0, 1'b1);
      check_counters("p1p3");

      // processor with no connections
      prog_n[2] = 0;
      run_round(4'b0100, 1'b0, 1'b0);
      check_counters("zero_conn");

      // clear in IDLE
      @(negedge clk);
      clear_tokens = 1'b1;
      @(negedge clk);
      clear_tokens = 1'b0;
      zero_exp();
      check_counters("clear_idle");

      // saturation toward the positive and negative limits
      prog_n[0] = 1;
      set_conn(0, 0, 2, 7, -8);
      for (int r = 0; r < 20; r++) begin
         run_round(4'b0001, 1'b0, 1'b0);
         tok_rd_id = 3'd2;
         #1;
         chk("sat_up_good", int'(tok_good), exp_g[2]);
         chk("sat_up_bad",  int'(tok_bad),  exp_b[2]);
      end
      chk("sat_max", int'(tok_good), 127);
      chk("sat_min_bad", int'(tok_bad), -128);
      set_conn(0, 0, 2, -8, 7);
      for (int r = 0; r < 40; r++) begin
         run_round(4'b0001, 1'b0, 1'b0);
         tok_rd_id = 3'd2;
         #1;
         chk("sat_dn_good", int'(tok_good), exp_g[2]);
         chk("sat_dn_bad",  int'(tok_bad),  exp_b[2]);
      end
      chk("sat_min", int'(tok_good), -128);
      chk("sat_max_bad", int'(tok_bad), 127);

      // out-of-range targets dropped; start/clear while busy ignored
      prog_n[0] = 3;
      set_conn(0, 0, 5, 3, 3);
      set_conn(0, 1, 1, 1, -1);
      set_conn(0, 2, 6, -2, -2);
      run_round(4'b0001, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("ignored_start_busy", busy, 0);
      check_counters("oor");
      @(negedge clk);
      clear_tokens = 1'b1;
      @(negedge clk);
      clear_tokens = 1'b0;
      zero_exp();
      check_counters("clear_after");

      // reset during ITER
      prog_n[0] = 2;
      set_conn(0, 0, 1, 3, 2);
      set_conn(0, 1, 2, 1, 1);
      @(negedge clk);
      start     = 1'b1;
      fire_mask = 4'b0001;
      @(negedge clk);
      start = 1'b0;
      wait_load(ok);
      @(negedge clk);
      net_valid           = 1'b1;
      net_target_id       = 3'd1;
      net_new_good_tokens = 4'sd3;
      net_new_bad_tokens  = 4'sd2;
      @(negedge clk);
      net_valid = 1'b0;
      tok_rd_id = 3'd1;
      #1;
      chk("pre_rst_good", int'(tok_good), 3);
      chk("pre_rst_ins", net_instruction, 3'b111);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_ins", net_instruction, 0);
      chk("midrst_pid", net_processor_id, 0);
      check_counters("midrst");
      run_round(4'b0001, 1'b0, 1'b0);
      check_counters("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
